apb_fsm_controller: RTL

Sequencing controller for the AHB-to-APB bridge. It consumes the qualified transfer strobe, address, write data and peripheral select produced by the bridge's AHB slave interface. It drives the APB setup/enable protocol toward the interrupt, counter-timer and remap peripherals, and generates `Hreadyout` back to the AHB side so that each AHB transfer maps to exactly one APB transfer.

---
 rtl/apb_fsm_controller.sv | 98 +++++++++
 1 files changed

// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller: AHB-to-APB sequencing FSM mapping each AHB transfer to one APB setup/enable transfer.
// Optional APB_PREADY_EN adds a Pready input that stretches the enable phase.
module apb_fsm_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              valid,
  input  logic              Hwrite,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [2:0]        tsel,
`ifdef APB_PREADY_EN
  input  logic              Pready,
`endif
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic [2:0]        Psel,
  output logic              Pwrite,
  output logic              Penable,
  output logic              Hreadyout
);
  typedef enum logic [2:0] {IDLE, WWAIT, READ, WRITE, RENABLE, WENABLE} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_paddr, w_paddr, r_addr_q, w_addr_q;
  logic [DATA_W-1:0] r_pwdata, w_pwdata;
  logic [2:0]        r_psel, w_psel, r_sel_q, w_sel_q;
  logic              r_pwrite, w_pwrite, r_penable, w_penable;
  logic              w_en, w_done, w_accept;
  assign w_en = (r_state == RENABLE) || (r_state == WENABLE);
`ifdef APB_PREADY_EN
  assign w_done = Pready || (r_psel == 3'b000);
`else
  assign w_done = 1'b1;
`endif
  assign Hreadyout = (r_state == IDLE) || (w_en && w_done);
  assign w_accept  = Hreadyout && valid;
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_state   <= IDLE;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_psel    <= '0;
      r_pwrite  <= 1'b0;
      r_penable <= 1'b0;
      r_addr_q  <= '0;
      r_sel_q   <= '0;
    end else begin
      r_state   <= w_next;
      r_paddr   <= w_paddr;
      r_pwdata  <= w_pwdata;
      r_psel    <= w_psel;
      r_pwrite  <= w_pwrite;
      r_penable <= w_penable;
      r_addr_q  <= w_addr_q;
      r_sel_q   <= w_sel_q;
    end
  end
  always_comb begin
    w_next = w_accept ? (Hwrite ? WWAIT : READ) :
             (r_state == WWAIT) ? WRITE :
             (r_state == READ)  ? RENABLE :
             (r_state == WRITE) ? WENABLE :
             (w_en && w_done)   ? IDLE : r_state;
  end
  // Writes park the address in addr_q/sel_q for one cycle so Hwdata can be captured alongside.
  always_comb begin
    w_paddr   = r_paddr;
    w_pwdata  = r_pwdata;
    w_psel    = r_psel;
    w_pwrite  = r_pwrite;
    w_penable = r_penable;
    w_addr_q  = w_accept ? Haddr : r_addr_q;
    w_sel_q   = w_accept ? tsel : r_sel_q;
    if (w_accept) begin
      w_psel    = Hwrite ? 3'b000 : tsel;
      w_penable = 1'b0;
      w_paddr   = Hwrite ? r_paddr : Haddr;
      w_pwrite  = Hwrite ? r_pwrite : 1'b0;
    end else if (r_state == WWAIT) begin
      w_paddr  = r_addr_q;
      w_psel   = r_sel_q;
      w_pwrite = 1'b1;
      w_pwdata = Hwdata;
    end else if (r_state == READ || r_state == WRITE) begin
      w_penable = 1'b1;
    end else if (w_en && w_done) begin
      w_psel    = 3'b000;
      w_penable = 1'b0;
    end
  end
  assign Paddr   = r_paddr;
  assign Pwdata  = r_pwdata;
  assign Psel    = r_psel;
  assign Pwrite  = r_pwrite;
  assign Penable = r_penable;
endmodule
